// File: rtl/slot_bus_glue.sv
// Slot bus glue: per-slot register strobes, CnXX/C800 ROM enable/addressing and expansion-space ownership.
// Define SLOT_BUS_GLUE_CFFF_READ_ONLY_EN to release C800 ownership only on CFFF reads.
module slot_bus_glue #(
    parameter int NUM_SLOTS = 7,
    parameter int SLOT_W    = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [11:0]          addr,
    input  logic                 rw,
    input  logic [NUM_SLOTS-1:0] devsel_n,
    input  logic [NUM_SLOTS-1:0] iosel_n,
    input  logic                 io_strobe_n,
    output logic [3:0]           reg_sel,
    output logic [NUM_SLOTS-1:0] reg_rd_stb,
    output logic [NUM_SLOTS-1:0] reg_wr_stb,
    output logic                 rom_en_n,
    output logic [SLOT_W+10:0]   rom_addr,
    output logic                 c8_active,
    output logic [SLOT_W-1:0]    c8_owner,
    output logic                 bus_drive,
    output logic                 conflict
);

    typedef enum logic {IDLE, OWNED} state_e;

    state_e                 state_q, state_d;
    logic [SLOT_W-1:0]      owner_q, owner_d;
    logic [NUM_SLOTS-1:0]   devsel_prev_q;
    logic                   armed_q;
    logic [NUM_SLOTS-1:0]   rd_stb_q, rd_stb_d;
    logic [NUM_SLOTS-1:0]   wr_stb_q, wr_stb_d;
    logic [3:0]             reg_sel_q, reg_sel_d;
    logic                   rom_en_n_q, rom_en_n_d;
    logic [SLOT_W+10:0]     rom_addr_q, rom_addr_d;
    logic                   bus_drive_q, bus_drive_d;
    logic                   conflict_q, conflict_d;

    logic [NUM_SLOTS-1:0]   dev_act, io_act;
    logic                   dev_hit, io_hit, dev_multi, io_multi;
    logic [SLOT_W-1:0]      dev_idx, io_idx;
    logic                   c8_hit, rel_ok;

`ifdef SLOT_BUS_GLUE_CFFF_READ_ONLY_EN
    assign rel_ok = rw;
`else
    assign rel_ok = 1'b1;
`endif

    assign dev_act   = ~devsel_n;
    assign io_act    = ~iosel_n;
    assign dev_hit   = |dev_act;
    assign io_hit    = |io_act;
    assign dev_multi = |(dev_act & (dev_act - NUM_SLOTS'(1)));
    assign io_multi  = |(io_act & (io_act - NUM_SLOTS'(1)));
    assign c8_hit    = (state_q == OWNED) && !io_strobe_n;

    // Lowest-numbered active select wins; the descending loop leaves it last.
    always_comb begin
        dev_idx = '0;
        io_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (dev_act[i]) dev_idx = SLOT_W'(i);
            if (io_act[i])  io_idx  = SLOT_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (io_hit) begin
            state_d = OWNED;
            owner_d = io_idx;
        end else if (c8_hit && (addr == 12'hFFF) && rel_ok) begin
            state_d = IDLE;
        end
    end

    // armed_q suppresses edge detection on the first sample after reset,
    // so a select already low when reset lifts is not mistaken for a new access.
    always_comb begin
        rd_stb_d    = '0;
        wr_stb_d    = '0;
        reg_sel_d   = reg_sel_q;
        rom_en_n_d  = 1'b1;
        rom_addr_d  = rom_addr_q;
        if (dev_hit && armed_q && devsel_prev_q[dev_idx]) begin
            if (rw) rd_stb_d[dev_idx] = 1'b1;
            else    wr_stb_d[dev_idx] = 1'b1;
            reg_sel_d = addr[3:0];
        end
        if (io_hit) begin
            rom_en_n_d = 1'b0;
            rom_addr_d = {io_idx, 3'b111, addr[7:0]};
        end else if (c8_hit) begin
            rom_en_n_d = 1'b0;
            rom_addr_d = {owner_q, addr[10:0]};
        end
        bus_drive_d = rw && (!rom_en_n_d || dev_hit);
        conflict_d  = dev_multi || io_multi;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            devsel_prev_q <= '1;
            armed_q       <= 1'b0;
            rd_stb_q      <= '0;
            wr_stb_q      <= '0;
            reg_sel_q     <= '0;
            rom_en_n_q    <= 1'b1;
            rom_addr_q    <= '0;
            bus_drive_q   <= 1'b0;
            conflict_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            devsel_prev_q <= devsel_n;
            armed_q       <= 1'b1;
            rd_stb_q      <= rd_stb_d;
            wr_stb_q      <= wr_stb_d;
            reg_sel_q     <= reg_sel_d;
            rom_en_n_q    <= rom_en_n_d;
            rom_addr_q    <= rom_addr_d;
            bus_drive_q   <= bus_drive_d;
            conflict_q    <= conflict_d;
        end
    end

    assign reg_sel    = reg_sel_q;
    assign reg_rd_stb = rd_stb_q;
    assign reg_wr_stb = wr_stb_q;
    assign rom_en_n   = rom_en_n_q;
    assign rom_addr   = rom_addr_q;
    assign c8_active  = (state_q == OWNED);
    assign c8_owner   = owner_q;
    assign bus_drive  = bus_drive_q;
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_slot_bus_glue.sv
// Directed-vector bench for slot_bus_glue: a table of per-cycle stimulus/expectation records
// followed by hand-written reset sequences.
module tb_slot_bus_glue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] addr;
    logic        rw;
    logic [6:0]  devsel_n;
    logic [6:0]  iosel_n;
    logic        io_strobe_n;
    logic [3:0]  reg_sel;
    logic [6:0]  reg_rd_stb;
    logic [6:0]  reg_wr_stb;
    logic        rom_en_n;
    logic [13:0] rom_addr;
    logic        c8_active;
    logic [2:0]  c8_owner;
    logic        bus_drive;
    logic        conflict;

    int total = 0;
    int bad   = 0;

`ifdef SLOT_BUS_GLUE_CFFF_READ_ONLY_EN
    localparam logic CFFF_WR_ACT = 1'b1;
`else
    localparam logic CFFF_WR_ACT = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [6:0]  dev;
        logic [6:0]  io;
        logic        strb;
        logic [11:0] a;
        logic        r;
        logic [6:0]  rd;
        logic [6:0]  wr;
        logic [3:0]  sel;
        logic        en;
        logic [13:0] ra;
        logic        act;
        logic [2:0]  own;
        logic        bd;
        logic        cf;
    } vec_t;

    vec_t vecs[$];

    slot_bus_glue #(.NUM_SLOTS(7), .SLOT_W(3)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .addr        (addr),
        .rw          (rw),
        .devsel_n    (devsel_n),
        .iosel_n     (iosel_n),
        .io_strobe_n (io_strobe_n),
        .reg_sel     (reg_sel),
        .reg_rd_stb  (reg_rd_stb),
        .reg_wr_stb  (reg_wr_stb),
        .rom_en_n    (rom_en_n),
        .rom_addr    (rom_addr),
        .c8_active   (c8_active),
        .c8_owner    (c8_owner),
        .bus_drive   (bus_drive),
        .conflict    (conflict)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(string n, logic [6:0] dv, logic [6:0] io, logic s, logic [11:0] a,
                                logic r, logic [6:0] rd, logic [6:0] wr, logic [3:0] sel, logic en,
                                logic [13:0] ra, logic act, logic [2:0] own, logic bd, logic cf);
        vec_t v;
        v.name = n; v.dev = dv; v.io = io; v.strb = s; v.a = a; v.r = r;
        v.rd = rd; v.wr = wr; v.sel = sel; v.en = en; v.ra = ra;
        v.act = act; v.own = own; v.bd = bd; v.cf = cf;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        devsel_n    = v.dev;
        iosel_n     = v.io;
        io_strobe_n = v.strb;
        addr        = v.a;
        rw          = v.r;
    endtask

    task automatic checkOutput(input vec_t v);
        checkField({v.name, " rd_stb"},    32'(reg_rd_stb), 32'(v.rd));
        checkField({v.name, " wr_stb"},    32'(reg_wr_stb), 32'(v.wr));
        checkField({v.name, " reg_sel"},   32'(reg_sel),    32'(v.sel));
        checkField({v.name, " rom_en_n"},  32'(rom_en_n),   32'(v.en));
        checkField({v.name, " rom_addr"},  32'(rom_addr),   32'(v.ra));
        checkField({v.name, " c8_active"}, 32'(c8_active),  32'(v.act));
        checkField({v.name, " c8_owner"},  32'(c8_owner),   32'(v.own));
        checkField({v.name, " bus_drive"}, 32'(bus_drive),  32'(v.bd));
        checkField({v.name, " conflict"},  32'(conflict),   32'(v.cf));
    endtask

    task automatic checkReset(input string tag);
        checkOutput(mk(tag, 7'h7F, 7'h7F, 1'b1, 12'h000, 1'b0,
                       7'h00, 7'h00, 4'h0, 1'b1, 14'h0000, 1'b0, 3'd0, 1'b0, 1'b0));
    endtask

    task automatic idleInputs();
        devsel_n = 7'h7F; iosel_n = 7'h7F; io_strobe_n = 1'b1; addr = 12'h000; rw = 1'b0;
    endtask

    initial begin
        //            name        dev    io     s  addr    rw  rd     wr     sel  en  ra        act own bd cf
        vecs.push_back(mk("idle0",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'h0, 1, 14'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("rd2a",     7'h7B, 7'h7F, 1, 12'h0A5, 1, 7'h04, 7'h00, 4'h5, 1, 14'h0000, 0, 0, 1, 0));
        vecs.push_back(mk("rd2b",     7'h7B, 7'h7F, 1, 12'h0A5, 1, 7'h00, 7'h00, 4'h5, 1, 14'h0000, 0, 0, 1, 0));
        vecs.push_back(mk("rd2c",     7'h7B, 7'h7F, 1, 12'h0A5, 1, 7'h00, 7'h00, 4'h5, 1, 14'h0000, 0, 0, 1, 0));
        vecs.push_back(mk("idle1",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'h5, 1, 14'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("wr6",      7'h3F, 7'h7F, 1, 12'h0C3, 0, 7'h00, 7'h40, 4'h3, 1, 14'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("idle2",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'h3, 1, 14'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("claim4",   7'h7F, 7'h6F, 1, 12'h312, 1, 7'h00, 7'h00, 4'h3, 0, 14'h2712, 1, 4, 1, 0));
        vecs.push_back(mk("idle3",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'h3, 1, 14'h2712, 1, 4, 0, 0));
        vecs.push_back(mk("c8rd",     7'h7F, 7'h7F, 0, 12'h9AB, 1, 7'h00, 7'h00, 4'h3, 0, 14'h21AB, 1, 4, 1, 0));
        vecs.push_back(mk("cfffrd",   7'h7F, 7'h7F, 0, 12'hFFF, 1, 7'h00, 7'h00, 4'h3, 0, 14'h27FF, 0, 4, 1, 0));
        vecs.push_back(mk("idle4",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'h3, 1, 14'h27FF, 0, 4, 0, 0));
        vecs.push_back(mk("strbIdle", 7'h7F, 7'h7F, 0, 12'h800, 1, 7'h00, 7'h00, 4'h3, 1, 14'h27FF, 0, 4, 0, 0));
        vecs.push_back(mk("ioConf",   7'h7F, 7'h5D, 1, 12'h345, 0, 7'h00, 7'h00, 4'h3, 0, 14'h0F45, 1, 1, 0, 1));
        vecs.push_back(mk("idle5",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'h3, 1, 14'h0F45, 1, 1, 0, 0));
        vecs.push_back(mk("devConf",  7'h76, 7'h7F, 1, 12'h00E, 1, 7'h01, 7'h00, 4'hE, 1, 14'h0F45, 1, 1, 1, 1));
        vecs.push_back(mk("claim3",   7'h7F, 7'h77, 1, 12'h3AA, 1, 7'h00, 7'h00, 4'hE, 0, 14'h1FAA, 1, 3, 1, 0));
        vecs.push_back(mk("cfffwr",   7'h7F, 7'h7F, 0, 12'hFFF, 0, 7'h00, 7'h00, 4'hE, 0, 14'h1FFF, CFFF_WR_ACT, 3, 0, 0));
        vecs.push_back(mk("claimRel", 7'h7F, 7'h5F, 0, 12'hFFF, 1, 7'h00, 7'h00, 4'hE, 0, 14'h2FFF, 1, 5, 1, 0));
        vecs.push_back(mk("idle6",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'hE, 1, 14'h2FFF, 1, 5, 0, 0));
        vecs.push_back(mk("claimRel2",7'h7F, 7'h7B, 0, 12'hFFF, 1, 7'h00, 7'h00, 4'hE, 0, 14'h17FF, 1, 2, 1, 0));
        vecs.push_back(mk("cfffrd2",  7'h7F, 7'h7F, 0, 12'hFFF, 1, 7'h00, 7'h00, 4'hE, 0, 14'h17FF, 0, 2, 1, 0));
        vecs.push_back(mk("idle7",    7'h7F, 7'h7F, 1, 12'h000, 0, 7'h00, 7'h00, 4'hE, 1, 14'h17FF, 0, 2, 0, 0));

        reset_n = 1'b0;
        idleInputs();
        repeat (2) @(posedge clock);
        #1;
        checkReset("por");
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clock);
            #1;
            checkOutput(vecs[i]);
        end

        // Reset asserted between clock edges while a register read is starting.
        devsel_n = 7'h7D; rw = 1'b1; addr = 12'h0A7;
        #2;
        reset_n = 1'b0;
        #1;
        checkReset("asyncMid");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            checkField($sformatf("heldDev%0d rd_stb", k), 32'(reg_rd_stb), 32'h0);
            checkField($sformatf("heldDev%0d reg_sel", k), 32'(reg_sel), 32'h0);
        end

        // A ROM select held low across reset release claims on the first edge.
        idleInputs();
        iosel_n = 7'h3F; addr = 12'h010;
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkField("heldIo c8_active", 32'(c8_active), 32'h1);
        checkField("heldIo c8_owner",  32'(c8_owner),  32'h6);
        checkField("heldIo rom_en_n",  32'(rom_en_n),  32'h0);
        checkField("heldIo rom_addr",  32'(rom_addr),  32'h3710);

        idleInputs();
        @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
